// File: rtl/imsic_pkg.sv
// -----------------------------------------------------------------------------
// imsic_pkg
// Shared IMSIC definitions:
//   - MSI sender FSM state enum
//   - width-derivation helpers for the hart / file / identity fields
//   - MSI_INFO field offsets; the layout is {hart, file, id}, MSB..LSB
// -----------------------------------------------------------------------------
package imsic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } msi_state_e;

    // Index width for n items. It is never narrower than one bit, so a
    // single-item field still has a real wire.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int hart_width(input int nr_harts);
        return clog2_min1(nr_harts);
    endfunction

    function automatic int file_width(input int nr_files);
        return clog2_min1(nr_files);
    endfunction

    function automatic int src_width(input int nr_src);
        return clog2_min1(nr_src);
    endfunction

    // The counter must hold the larger of the two phase lengths.
    function automatic int cnt_width(input int vld_high, input int info_hold);
        return $clog2(((vld_high > info_hold) ? vld_high : info_hold) + 1);
    endfunction

    function automatic int info_width(input int hart_w, input int file_w, input int src_w);
        return hart_w + file_w + src_w;
    endfunction

    // MSI_INFO field offsets.
    function automatic int info_id_lsb();
        return 0;
    endfunction

    function automatic int info_file_lsb(input int src_w);
        return src_w;
    endfunction

    function automatic int info_hart_lsb(input int src_w, input int file_w);
        return src_w + file_w;
    endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// -----------------------------------------------------------------------------
// imsic_msi_fifo
// Synchronous request FIFO. DEPTH must be a power of two and at least 2.
// rdata is valid combinationally whenever empty is 0.
// A push and a pop in the same cycle are both honoured.
// A push while full is ignored, and a pop while empty is ignored.
// Ports:
//   clk, rstn      clock, async active-low reset
//   push, wdata    write strobe and data
//   pop            read strobe (consumes rdata)
//   rdata          head entry
//   full, empty    occupancy flags
// -----------------------------------------------------------------------------
module imsic_msi_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately left unreset. Only the pointers and count
    // say what is valid, and a reset on the array would turn it into flops.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // The pointers wrap naturally because DEPTH is a power of two.
    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples pre-edge values no matter what order the blocks run in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imsic_msi_sender.sv
// -----------------------------------------------------------------------------
// imsic_msi_sender
// Bus-side MSI transmitter. Decoded seteipnum writes are range-checked and
// buffered. Each one is then sent as {hart, file, id} on o_msi_info, with
// o_msi_info_vld held high for VLD_HIGH_CYC cycles. After vld falls, the info
// stays frozen for at least INFO_HOLD_CYC + 1 cycles, so a resynchronising
// receiver can capture it on the falling edge of vld.
// Ports:
//   clk, rstn        clock, async active-low reset
//   i_msi_wr_vld     write valid        o_msi_wr_rdy   not full
//   i_msi_wr_hart    target hart        i_msi_wr_file  target file
//   i_msi_wr_data    identity (32 bit)
//   o_msi_info       {hart,file,id}     o_msi_info_vld delivery strobe
//   o_msi_drop       1-cycle pulse for an accepted but illegal write
//   o_busy           FIFO non-empty or a message in flight
// -----------------------------------------------------------------------------
module imsic_msi_sender
    import imsic_pkg::*;
#(
    parameter  int NR_INTP_FILES   = 7,
    parameter  int NR_HARTS        = 4,
    parameter  int NR_SRC          = 32,
    parameter  int FIFO_DEPTH      = 4,
    parameter  int VLD_HIGH_CYC    = 4,
    parameter  int INFO_HOLD_CYC   = 6,
    localparam int NR_HARTS_WIDTH  = hart_width(NR_HARTS),
    localparam int INTP_FILE_WIDTH = file_width(NR_INTP_FILES),
    localparam int NR_SRC_WIDTH    = src_width(NR_SRC),
    localparam int MSI_INFO_WIDTH  = info_width(NR_HARTS_WIDTH, INTP_FILE_WIDTH, NR_SRC_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_msi_wr_vld,
    output logic                       o_msi_wr_rdy,
    input  logic [NR_HARTS_WIDTH-1:0]  i_msi_wr_hart,
    input  logic [INTP_FILE_WIDTH-1:0] i_msi_wr_file,
    input  logic [31:0]                i_msi_wr_data,
    output logic [MSI_INFO_WIDTH-1:0]  o_msi_info,
    output logic                       o_msi_info_vld,
    output logic                       o_msi_drop,
    output logic                       o_busy
);

    localparam int                CNT_W     = cnt_width(VLD_HIGH_CYC, INFO_HOLD_CYC);
    localparam logic [CNT_W-1:0]  VLD_LOAD  = CNT_W'(VLD_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(INFO_HOLD_CYC - 1);
    localparam logic [31:0]       HARTS_U   = 32'(NR_HARTS);
    localparam logic [31:0]       FILES_U   = 32'(NR_INTP_FILES);
    localparam logic [31:0]       SRC_U     = 32'(NR_SRC);

    msi_state_e                state, state_d;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic [MSI_INFO_WIDTH-1:0] info_d;
    logic                      vld_d;
    logic                      accept;
    logic                      legal;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [MSI_INFO_WIDTH-1:0] fifo_rdata;

    // The identity is checked against the full 32-bit write data. Upper bits
    // are only discarded after the check has passed.
    assign legal  = (32'(i_msi_wr_hart) < HARTS_U)
                  && (32'(i_msi_wr_file) < FILES_U)
                  && (i_msi_wr_data != 32'd0)
                  && (i_msi_wr_data < SRC_U);
    assign accept = i_msi_wr_vld & o_msi_wr_rdy;
    assign push   = accept & legal;

    assign o_msi_wr_rdy = ~fifo_full;
    assign o_busy       = ~fifo_empty | (state != IDLE);

    imsic_msi_fifo #(
        .WIDTH (MSI_INFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata ({i_msi_wr_hart, i_msi_wr_file, i_msi_wr_data[NR_SRC_WIDTH-1:0]}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // o_msi_info is only reloaded on the IDLE->ASSERT edge. Through ASSERT
    // and HOLD it stays frozen, which is what the receiver's falling-edge
    // capture depends on.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state;
        cnt_d   = cnt;
        info_d  = o_msi_info;
        vld_d   = o_msi_info_vld;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    info_d  = fifo_rdata;
                    vld_d   = 1'b1;
                    cnt_d   = VLD_LOAD;
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    vld_d   = 1'b0;
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            cnt            <= '0;
            o_msi_info     <= '0;
            o_msi_info_vld <= 1'b0;
            o_msi_drop     <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            o_msi_info     <= info_d;
            o_msi_info_vld <= vld_d;
            o_msi_drop     <= accept & ~legal;
        end
    end

endmodule

// File: tb/tb_imsic_msi_sender.sv
// -----------------------------------------------------------------------------
// tb_imsic_msi_sender
// Directed bench for imsic_msi_sender. NR_HARTS is 3, so a hart index of 3 is
// out of range while the field is still 2 bits wide.
// A negedge monitor records every delivery and checks the pulse shape and the
// stability of the info.
// -----------------------------------------------------------------------------
module tb_imsic_msi_sender;

    localparam int HW = 2;
    localparam int FW = 3;
    localparam int SW = 5;
    localparam int IW = HW + FW + SW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_vld;
    logic          wr_rdy;
    logic [HW-1:0] wr_hart;
    logic [FW-1:0] wr_file;
    logic [31:0]   wr_data;
    logic [IW-1:0] info;
    logic          info_vld;
    logic          drop;
    logic          busy;

    int tests = 0;
    int fails = 0;

    imsic_msi_sender #(
        .NR_INTP_FILES (7),
        .NR_HARTS      (3),
        .NR_SRC        (32),
        .FIFO_DEPTH    (4),
        .VLD_HIGH_CYC  (4),
        .INFO_HOLD_CYC (6)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_msi_wr_vld   (wr_vld),
        .o_msi_wr_rdy   (wr_rdy),
        .i_msi_wr_hart  (wr_hart),
        .i_msi_wr_file  (wr_file),
        .i_msi_wr_data  (wr_data),
        .o_msi_info     (info),
        .o_msi_info_vld (info_vld),
        .o_msi_drop     (drop),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] pack(input logic [HW-1:0] h, input logic [FW-1:0] f,
                                           input logic [31:0] d);
        return {h, f, d[SW-1:0]};
    endfunction

    // ---------------- negedge monitor ----------------
    logic          prev_vld  = 1'b0;
    logic [IW-1:0] prev_info = '0;
    int            cyc       = 0;
    int            hi_len    = 0;
    int            lo_len    = 0;
    bit            have_fall = 1'b0;
    bit            mon_en    = 1'b0;
    int            rise_all  = 0;
    int            drop_cnt  = 0;
    logic [IW-1:0] got_q[$];
    int            rise_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (info_vld === 1'b1 && prev_vld !== 1'b1) rise_all++;
        if (drop === 1'b1) drop_cnt++;
        if (mon_en) begin
            if (info_vld && !prev_vld) begin
                got_q.push_back(info);
                rise_cyc.push_back(cyc);
                if (have_fall) check("vld_low_gap_ge7", 32'(lo_len >= 7), 1);
                hi_len = 1;
            end else begin
                check("info_stable", 32'(info), 32'(prev_info));
                if (info_vld) begin
                    hi_len++;
                end else if (prev_vld) begin
                    check("vld_high_len", hi_len, 4);
                    have_fall = 1'b1;
                    lo_len    = 1;
                end else begin
                    lo_len++;
                end
            end
        end else begin
            have_fall = 1'b0;
            hi_len    = 0;
            lo_len    = 0;
        end
        prev_vld  = info_vld;
        prev_info = info;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one write and hold it until it is accepted. The task returns
    // 1 time unit after the accepting edge.
    task automatic send(input logic [HW-1:0] h, input logic [FW-1:0] f, input logic [31:0] d);
        int n = 0;
        wr_hart = h;
        wr_file = f;
        wr_data = d;
        wr_vld  = 1'b1;
        while (wr_rdy !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("send_rdy", 32'(wr_rdy), 1);
        tick();
        wr_vld = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0 || info_vld !== 1'b0) && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 0);
    endtask

    logic [HW-1:0] bb_h [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [FW-1:0] bb_f [6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [31:0]   bb_d [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd30, 32'd17};

    initial begin
        int base;
        int idx;
        int acc_pre;
        int stall;
        int n;
        logic r;

        // ---- reset ----
        rstn    = 1'b0;
        wr_vld  = 1'b0;
        wr_hart = '0;
        wr_file = '0;
        wr_data = '0;
        #23;
        check("rst_info", 32'(info), 0);
        check("rst_vld", 32'(info_vld), 0);
        check("rst_drop", 32'(drop), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rdy", 32'(wr_rdy), 1);
        rstn = 1'b1;
        tick();
        mon_en = 1'b1;

        // ---- single legal write ----
        // Inputs are driven after edge t and accepted at t+1. vld is first
        // seen after t+2.
        send(2'd1, 3'd2, 32'd5);
        check("single_vld_not_yet", 32'(info_vld), 0);
        check("single_busy", 32'(busy), 1);
        tick();
        check("single_vld_rise", 32'(info_vld), 1);
        check("single_info", 32'(info), 32'h145);
        check("single_no_drop", 32'(drop), 0);
        wait_idle("single_idle");
        check("single_count", got_q.size(), 1);
        check("single_got", 32'(got_q[0]), 32'h145);

        // ---- illegal writes: data=0, data=32, file=7, hart=3, high data bit ----
        send(2'd1, 3'd2, 32'd0);
        check("drop_d0_pulse", 32'(drop), 1);
        check("drop_d0_busy", 32'(busy), 0);
        tick();
        check("drop_d0_clear", 32'(drop), 0);
        send(2'd1, 3'd2, 32'd32);
        check("drop_d32_pulse", 32'(drop), 1);
        check("drop_d32_busy", 32'(busy), 0);
        tick();
        send(2'd1, 3'd7, 32'd5);
        check("drop_f7_pulse", 32'(drop), 1);
        check("drop_f7_busy", 32'(busy), 0);
        tick();
        send(2'd3, 3'd2, 32'd5);
        check("drop_h3_pulse", 32'(drop), 1);
        check("drop_h3_busy", 32'(busy), 0);
        tick();
        send(2'd1, 3'd2, 32'h8000_0005);
        check("drop_hibit_pulse", 32'(drop), 1);
        check("drop_hibit_rdy", 32'(wr_rdy), 1);
        repeat (3) tick();
        check("drop_vld_low", 32'(info_vld), 0);
        check("drop_total", drop_cnt, 5);
        check("drop_no_delivery", got_q.size(), 1);

        // ---- legal corner: hart 2, file 6, id 31 ----
        send(2'd2, 3'd6, 32'd31);
        wait_idle("corner_idle");
        check("corner_count", got_q.size(), 2);
        check("corner_got", 32'(got_q[1]), 32'h2DF);

        // ---- six back-to-back writes with vld held ----
        // The first pop happens on the second accepting edge, so five writes
        // go in before the FIFO fills. rdy then stays low until the next pop,
        // 11 cycles after the first one.
        base    = got_q.size();
        idx     = 0;
        acc_pre = 0;
        stall   = 0;
        n       = 0;
        wr_hart = bb_h[0];
        wr_file = bb_f[0];
        wr_data = bb_d[0];
        wr_vld  = 1'b1;
        while (idx < 6 && n < 200) begin
            r = wr_rdy;
            if (!r) stall++;
            tick();
            n++;
            if (r) begin
                if (stall == 0) acc_pre++;
                idx++;
                if (idx < 6) begin
                    wr_hart = bb_h[idx];
                    wr_file = bb_f[idx];
                    wr_data = bb_d[idx];
                end
            end
        end
        wr_vld = 1'b0;
        check("b2b_all_accepted", idx, 6);
        check("b2b_accepts_before_full", acc_pre, 5);
        check("b2b_stall_cycles", stall, 8);
        wait_idle("b2b_idle");
        check("b2b_count", got_q.size(), base + 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b2b_order_%0d", i), 32'(got_q[base + i]),
                  32'(pack(bb_h[i], bb_f[i], bb_d[i])));
        end
        for (int i = 1; i < 6; i++) begin
            check($sformatf("b2b_period_%0d", i), rise_cyc[base + i] - rise_cyc[base + i - 1], 11);
        end

        // ---- push and pop in the same cycle with one entry ----
        base = got_q.size();
        send(2'd0, 3'd1, 32'd9);
        send(2'd2, 3'd5, 32'd20);
        check("pp_occupancy", 32'(dut.u_fifo.count), 1);
        check("pp_vld", 32'(info_vld), 1);
        check("pp_info_first", 32'(info), 32'(pack(2'd0, 3'd1, 32'd9)));
        wait_idle("pp_idle");
        check("pp_count", got_q.size(), base + 2);
        check("pp_got_a", 32'(got_q[base]), 32'(pack(2'd0, 3'd1, 32'd9)));
        check("pp_got_b", 32'(got_q[base + 1]), 32'(pack(2'd2, 3'd5, 32'd20)));

        // ---- reset during the second ASSERT cycle with requests queued ----
        send(2'd1, 3'd1, 32'd11);
        send(2'd1, 3'd2, 32'd12);
        send(2'd1, 3'd3, 32'd13);
        check("mrst_vld_before", 32'(info_vld), 1);
        check("mrst_queued", 32'(dut.u_fifo.count), 2);
        mon_en = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("mrst_vld", 32'(info_vld), 0);
        check("mrst_info", 32'(info), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_rdy", 32'(wr_rdy), 1);
        check("mrst_drop", 32'(drop), 0);
        base = rise_all;
        repeat (2) @(negedge clk);
        #2;
        rstn = 1'b1;
        repeat (40) tick();
        check("mrst_no_delivery", rise_all, base);
        check("mrst_post_busy", 32'(busy), 0);
        check("mrst_post_rdy", 32'(wr_rdy), 1);
        check("mrst_post_vld", 32'(info_vld), 0);
        check("final_drop_total", drop_cnt, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
